sd_block_reader: RTL and testbench

SD_BLOCK_READER -- requirements
Module: sd_block_reader

---
 rtl/sd_block_reader.sv | 244 ++++++++++++++++++++++++
 tb/tb_sd_block_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_reader.sv
// ---------------------------------------------------------------------------
// sd_block_reader
// Receives one SPI-mode SD data block after CMD17. The host has already seen
// the R1 response. This block clocks the card, waits for the start token,
// streams out the data bytes, and checks the trailing CRC16-CCITT.
//
// Ports
//   clk          system clock (the only clock)
//   rst          asynchronous active-high reset
//   start        one-clk pulse that begins a read (ignored while busy)
//   abort        synchronous abandon of the current read
//   miso         card data out
//   mosi         held high (the card only needs idle ones during a read)
//   sdclk        SPI clock to the card, idles high
//   byte_data    last received data byte, MSB first on the wire
//   byte_valid   one-clk qualifier for byte_data
//   done         one-clk pulse at the end of a read (ok, crc, token or timeout)
//   crc_error    received CRC differs from the computed one
//   token_error  a token other than 0xFE/0xFF arrived
//   err_code     low nibble of the offending token
//   timeout      no token arrived within TOKEN_TIMEOUT clks
//   busy         high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module sd_block_reader #(
  parameter int CLK_DIV_POWER2 = 2,
  parameter int TOKEN_TIMEOUT  = 270000,
  parameter int BLOCK_BYTES    = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       miso,
  output logic       mosi,
  output logic       sdclk,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       done,
  output logic       crc_error,
  output logic       token_error,
  output logic [3:0] err_code,
  output logic       timeout,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_CRC    = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  localparam int DW = CLK_DIV_POWER2;
  localparam int TW = $clog2(TOKEN_TIMEOUT + 1);
  localparam int IW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;

  // Last clk before sdclk rises: the card's bit is stable here.
  localparam logic [DW-1:0] TICK_VAL = DW'((1 << (DW - 1)) - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TOKEN_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(BLOCK_BYTES - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  // One bitwise step of CRC16-CCITT (poly 0x1021, non-reflected).
  function automatic logic [15:0] f_crc16_bit(input logic [15:0] crc, input logic bit_in);
    logic [15:0] v_poly;
    v_poly      = (crc[15] ^ bit_in) ? 16'h1021 : 16'h0000;
    f_crc16_bit = {crc[14:0], 1'b0} ^ v_poly;
  endfunction

  logic [2:0]    r_state;
  logic [DW-1:0] r_div_cnt;
  logic          r_sdclk;
  logic          r_busy;
  logic [6:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic [IW-1:0] r_idx;
  logic [15:0]   r_crc;
  logic [15:0]   r_crc_rx;
  logic [3:0]    r_crc_cnt;
  logic [7:0]    r_byte_data;
  logic          r_byte_valid;
  logic          r_done;
  logic          r_crc_error;
  logic          r_token_error;
  logic [3:0]    r_err_code;
  logic          r_timeout;

  logic [2:0]    w_state_next;
  logic [DW-1:0] w_div_next;
  logic          w_sdclk_next;
  logic          w_tick;
  logic          w_boundary;
  logic [7:0]    w_byte;
  logic          w_accept;
  logic          w_run;
  logic          w_token_seen;
  logic          w_expire;

  assign w_tick       = (r_state != ST_IDLE) && (r_div_cnt == TICK_VAL);
  assign w_byte       = {r_shift, miso};
  assign w_boundary   = w_tick && (r_bit_cnt == 3'd7);
  assign w_accept     = (r_state == ST_IDLE) && start;
  assign w_run        = (r_state != ST_IDLE) && !abort;
  // 0xFF is idle fill, anything else at a byte boundary is a token.
  assign w_token_seen = (r_state == ST_WAIT) && w_boundary && (w_byte != 8'hFF);
  // A token arriving on the expiry cycle takes precedence over the timeout.
  assign w_expire     = (r_state == ST_WAIT) && !w_token_seen && (r_tmo_cnt == TMO_LAST);

  assign w_div_next   = (r_state == ST_IDLE) ? {DW{1'b0}} : (r_div_cnt + DIV_ONE);
  // sdclk tracks the divider MSB of the coming cycle so it rises right after a sample.
  assign w_sdclk_next = (w_state_next == ST_IDLE) ? 1'b1 : w_div_next[DW-1];

  // Next-state selection; abort overrides every other transition.
  always_comb begin
    w_state_next = r_state;
    if ((r_state != ST_IDLE) && abort) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) w_state_next = ST_WAIT;
          else       w_state_next = ST_IDLE;
        end
        ST_WAIT: begin
          if (w_token_seen) begin
            if (w_byte == 8'hFE) w_state_next = ST_DATA;
            else                 w_state_next = ST_FINISH;
          end else if (w_expire) begin
            w_state_next = ST_FINISH;
          end else begin
            w_state_next = ST_WAIT;
          end
        end
        ST_DATA: begin
          if (w_boundary && (r_idx == IDX_LAST)) w_state_next = ST_CRC;
          else                                   w_state_next = ST_DATA;
        end
        ST_CRC: begin
          if (w_tick && (r_crc_cnt == 4'd15)) w_state_next = ST_FINISH;
          else                                w_state_next = ST_CRC;
        end
        ST_FINISH: w_state_next = ST_IDLE;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  // State register, clock divider and sdclk generation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_div_cnt <= {DW{1'b0}};
      r_sdclk   <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_div_cnt <= w_div_next;
      r_sdclk   <= w_sdclk_next;
      r_busy    <= (w_state_next != ST_IDLE);
    end
  end

  // Bit capture, token check, data streaming, CRC accumulation and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift       <= 7'd0;
      r_bit_cnt     <= 3'd0;
      r_tmo_cnt     <= {TW{1'b0}};
      r_idx         <= {IW{1'b0}};
      r_crc         <= 16'h0000;
      r_crc_rx      <= 16'h0000;
      r_crc_cnt     <= 4'd0;
      r_byte_data   <= 8'h00;
      r_byte_valid  <= 1'b0;
      r_done        <= 1'b0;
      r_crc_error   <= 1'b0;
      r_token_error <= 1'b0;
      r_err_code    <= 4'h0;
      r_timeout     <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_done       <= 1'b0;
      if (w_accept) begin
        r_shift       <= 7'd0;
        r_bit_cnt     <= 3'd0;
        r_tmo_cnt     <= {TW{1'b0}};
        r_idx         <= {IW{1'b0}};
        r_crc         <= 16'h0000;
        r_crc_rx      <= 16'h0000;
        r_crc_cnt     <= 4'd0;
        r_crc_error   <= 1'b0;
        r_token_error <= 1'b0;
        r_err_code    <= 4'h0;
        r_timeout     <= 1'b0;
      end else if (w_run) begin
        if (w_tick) begin
          r_shift   <= w_byte[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        case (r_state)
          ST_WAIT: begin
            r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
            if (w_token_seen && (w_byte != 8'hFE)) begin
              r_token_error <= 1'b1;
              r_err_code    <= w_byte[3:0];
            end
            if (w_expire) r_timeout <= 1'b1;
          end
          ST_DATA: begin
            if (w_tick) r_crc <= f_crc16_bit(r_crc, miso);
            if (w_boundary) begin
              r_byte_data  <= w_byte;
              r_byte_valid <= 1'b1;
              r_idx        <= r_idx + IDX_ONE;
            end
          end
          ST_CRC: begin
            if (w_tick) begin
              r_crc_rx  <= {r_crc_rx[14:0], miso};
              r_crc_cnt <= r_crc_cnt + 4'd1;
              if (r_crc_cnt == 4'd15) r_crc_error <= ({r_crc_rx[14:0], miso} != r_crc);
            end
          end
          ST_FINISH: r_done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign mosi        = 1'b1;
  assign sdclk       = r_sdclk;
  assign busy        = r_busy;
  assign byte_data   = r_byte_data;
  assign byte_valid  = r_byte_valid;
  assign done        = r_done;
  assign crc_error   = r_crc_error;
  assign token_error = r_token_error;
  assign err_code    = r_err_code;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_sd_block_reader.sv
// ---------------------------------------------------------------------------
// tb_sd_block_reader
// Directed bench: a card model shifts queued bits out on falling sdclk, a
// monitor logs byte_valid/done, and one task per scenario checks results.
// ---------------------------------------------------------------------------
module tb_sd_block_reader;

  localparam int P  = 1;
  localparam int TT = 1000;
  localparam int BB = 512;

  logic       clk, rst, start, abort, miso;
  logic       mosi, sdclk, byte_valid, done, crc_error, token_error, timeout, busy;
  logic [7:0] byte_data;
  logic [3:0] err_code;

  int n_checks = 0;
  int n_fails  = 0;

  logic       q_bits[$];
  logic [7:0] mon_q[$];
  int         done_cnt;

  sd_block_reader #(.CLK_DIV_POWER2(P), .TOKEN_TIMEOUT(TT), .BLOCK_BYTES(BB)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .miso(miso),
    .mosi(mosi), .sdclk(sdclk), .byte_data(byte_data), .byte_valid(byte_valid),
    .done(done), .crc_error(crc_error), .token_error(token_error),
    .err_code(err_code), .timeout(timeout), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Card model: next bit appears on each falling sdclk, idle ones otherwise.
  initial begin
    miso = 1'b1;
    forever begin
      @(negedge sdclk);
      if (q_bits.size() > 0) miso = q_bits.pop_front();
      else                   miso = 1'b1;
    end
  end

  // Monitor: log every byte_valid and done pulse.
  initial begin
    done_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (byte_valid === 1'b1) mon_q.push_back(byte_data);
      if (done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ (((c[15] ^ b) == 1'b1) ? 16'h1021 : 16'h0000);
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) q_bits.push_back(b[k]);
  endtask

  // Queue FF x3, FE, data bytes 0,1,2.. and the CRC (optionally last bit flipped).
  task automatic build_block(input bit flip);
    logic [15:0] c;
    logic [7:0]  d;
    c = 16'h0000;
    q_bits.delete();
    push_byte(8'hFF); push_byte(8'hFF); push_byte(8'hFF); push_byte(8'hFE);
    for (int i = 0; i < BB; i++) begin
      d = 8'(i);
      push_byte(d);
      for (int k = 7; k >= 0; k--) c = crc_step(c, d[k]);
    end
    if (flip) c[0] = ~c[0];
    push_byte(c[15:8]);
    push_byte(c[7:0]);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_bytes(input int base, input int n);
    for (int i = 0; i < 20000 && (mon_q.size() - base) < n; i++) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic do_block(input bit flip, input bit restart,
                          output int b0, output int d0, output bit fin);
    build_block(flip);
    b0 = mon_q.size();
    d0 = done_cnt;
    pulse_start();
    if (restart) begin
      wait_bytes(b0, 50);
      pulse_start();
    end
    fin = 1'b0;
    for (int i = 0; i < 25000 && !fin; i++) begin
      @(posedge clk); #2;
      if (done_cnt != d0) fin = 1'b1;
    end
    repeat (20) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    n_checks++; if (sdclk !== 1'b1) begin n_fails++; $display("FAIL rst_sdclk got %b want 1", sdclk); end
    n_checks++; if (mosi !== 1'b1) begin n_fails++; $display("FAIL rst_mosi got %b want 1", mosi); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL rst_busy got %b want 0", busy); end
    n_checks++; if (byte_valid !== 1'b0) begin n_fails++; $display("FAIL rst_byte_valid got %b want 0", byte_valid); end
    n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL rst_done got %b want 0", done); end
    n_checks++; if (byte_data !== 8'h00) begin n_fails++; $display("FAIL rst_byte_data got %h want 00", byte_data); end
    n_checks++; if ({crc_error, token_error, timeout, err_code} !== 7'd0) begin
      n_fails++; $display("FAIL rst_flags got %b want 0000000", {crc_error, token_error, timeout, err_code});
    end
  endtask

  task automatic test_good_block();
    int b0, d0; bit fin;
    do_block(1'b0, 1'b1, b0, d0, fin);
    n_checks++; if (fin !== 1'b1) begin n_fails++; $display("FAIL good_done_seen got %b want 1", fin); end
    n_checks++; if (mon_q.size() - b0 != BB) begin n_fails++; $display("FAIL good_count got %0d want %0d", mon_q.size() - b0, BB); end
    for (int i = 0; i < BB; i++) begin
      if (b0 + i < mon_q.size()) begin
        n_checks++;
        if (mon_q[b0 + i] !== 8'(i)) begin n_fails++; $display("FAIL good_byte[%0d] got %h want %h", i, mon_q[b0 + i], 8'(i)); end
      end
    end
    n_checks++; if (done_cnt - d0 != 1) begin n_fails++; $display("FAIL good_done_once got %0d want 1", done_cnt - d0); end
    n_checks++; if (crc_error !== 1'b0) begin n_fails++; $display("FAIL good_crc_error got %b want 0", crc_error); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL good_busy_after got %b want 0", busy); end
    n_checks++; if (sdclk !== 1'b1) begin n_fails++; $display("FAIL good_sdclk_idle got %b want 1", sdclk); end
    n_checks++; if (byte_data !== 8'hFF) begin n_fails++; $display("FAIL good_byte_hold got %h want ff", byte_data); end
  endtask

  task automatic test_bad_crc();
    int b0, d0; bit fin;
    do_block(1'b1, 1'b0, b0, d0, fin);
    n_checks++; if (fin !== 1'b1) begin n_fails++; $display("FAIL badcrc_done_seen got %b want 1", fin); end
    n_checks++; if (mon_q.size() - b0 != BB) begin n_fails++; $display("FAIL badcrc_count got %0d want %0d", mon_q.size() - b0, BB); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fails++; $display("FAIL badcrc_done_once got %0d want 1", done_cnt - d0); end
    n_checks++; if (crc_error !== 1'b1) begin n_fails++; $display("FAIL badcrc_crc_error got %b want 1", crc_error); end
  endtask

  task automatic test_token_error();
    int b0, d0;
    q_bits.delete();
    push_byte(8'hFF); push_byte(8'hFF); push_byte(8'h05);
    b0 = mon_q.size();
    d0 = done_cnt;
    pulse_start();
    repeat (120) @(posedge clk);
    #2;
    n_checks++; if (token_error !== 1'b1) begin n_fails++; $display("FAIL tok_token_error got %b want 1", token_error); end
    n_checks++; if (err_code !== 4'h5) begin n_fails++; $display("FAIL tok_err_code got %h want 5", err_code); end
    n_checks++; if (mon_q.size() != b0) begin n_fails++; $display("FAIL tok_no_bytes got %0d want 0", mon_q.size() - b0); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fails++; $display("FAIL tok_done_once got %0d want 1", done_cnt - d0); end
    n_checks++; if (crc_error !== 1'b0) begin n_fails++; $display("FAIL tok_crc_error_cleared got %b want 0", crc_error); end
  endtask

  task automatic test_timeout();
    int k;
    bit seen;
    q_bits.delete();
    pulse_start();
    seen = 1'b0;
    k = 0;
    while (k < TT + 100 && !seen) begin
      @(posedge clk); #1;
      k++;
      if (done === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b1) begin n_fails++; $display("FAIL tmo_done_seen got %b want 1", seen); end
    n_checks++; if (k < TT || k > TT + (1 << P)) begin n_fails++; $display("FAIL tmo_latency got %0d want %0d..%0d", k, TT, TT + (1 << P)); end
    n_checks++; if (timeout !== 1'b1) begin n_fails++; $display("FAIL tmo_flag got %b want 1", timeout); end
    n_checks++; if (token_error !== 1'b0) begin n_fails++; $display("FAIL tmo_token_error_cleared got %b want 0", token_error); end
    @(posedge clk); #2;
    n_checks++; if (sdclk !== 1'b1) begin n_fails++; $display("FAIL tmo_sdclk_idle got %b want 1", sdclk); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL tmo_busy got %b want 0", busy); end
  endtask

  task automatic test_abort();
    int b0, d0, cnt; bit fin;
    build_block(1'b0);
    b0 = mon_q.size();
    d0 = done_cnt;
    pulse_start();
    wait_bytes(b0, 101);
    @(negedge clk); abort = 1'b1;
    cnt = mon_q.size();
    @(posedge clk); #2;
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL abort_busy got %b want 0", busy); end
    n_checks++; if (sdclk !== 1'b1) begin n_fails++; $display("FAIL abort_sdclk got %b want 1", sdclk); end
    @(negedge clk); abort = 1'b0;
    repeat (60) @(posedge clk);
    #2;
    n_checks++; if (done_cnt != d0) begin n_fails++; $display("FAIL abort_no_done got %0d want 0", done_cnt - d0); end
    n_checks++; if (mon_q.size() != cnt) begin n_fails++; $display("FAIL abort_no_bytes got %0d want %0d", mon_q.size(), cnt); end
    n_checks++; if (timeout !== 1'b0 || token_error !== 1'b0) begin n_fails++; $display("FAIL abort_flags got %b%b want 00", timeout, token_error); end
    do_block(1'b0, 1'b0, b0, d0, fin);
    n_checks++; if (mon_q.size() - b0 != BB) begin n_fails++; $display("FAIL abort_next_count got %0d want %0d", mon_q.size() - b0, BB); end
    for (int i = 0; i < BB; i++) begin
      if (b0 + i < mon_q.size()) begin
        n_checks++;
        if (mon_q[b0 + i] !== 8'(i)) begin n_fails++; $display("FAIL abort_next_byte[%0d] got %h want %h", i, mon_q[b0 + i], 8'(i)); end
      end
    end
    n_checks++; if (crc_error !== 1'b0 || done_cnt - d0 != 1) begin n_fails++; $display("FAIL abort_next_end got crc=%b done=%0d want crc=0 done=1", crc_error, done_cnt - d0); end
  endtask

  task automatic test_rst_midblock();
    int b0, d0; bit fin;
    build_block(1'b0);
    b0 = mon_q.size();
    d0 = done_cnt;
    pulse_start();
    wait_bytes(b0, 101);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || sdclk !== 1'b1) begin n_fails++; $display("FAIL rstmid_idle got busy=%b sdclk=%b want 0 1", busy, sdclk); end
    n_checks++; if (byte_data !== 8'h00 || byte_valid !== 1'b0) begin n_fails++; $display("FAIL rstmid_data got %h/%b want 00/0", byte_data, byte_valid); end
    @(negedge clk); rst = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    n_checks++; if (done_cnt != d0) begin n_fails++; $display("FAIL rstmid_no_done got %0d want 0", done_cnt - d0); end
    do_block(1'b0, 1'b0, b0, d0, fin);
    n_checks++; if (mon_q.size() - b0 != BB) begin n_fails++; $display("FAIL rstmid_next_count got %0d want %0d", mon_q.size() - b0, BB); end
    for (int i = 0; i < BB; i++) begin
      if (b0 + i < mon_q.size()) begin
        n_checks++;
        if (mon_q[b0 + i] !== 8'(i)) begin n_fails++; $display("FAIL rstmid_next_byte[%0d] got %h want %h", i, mon_q[b0 + i], 8'(i)); end
      end
    end
    n_checks++; if (crc_error !== 1'b0 || done_cnt - d0 != 1) begin n_fails++; $display("FAIL rstmid_next_end got crc=%b done=%0d want crc=0 done=1", crc_error, done_cnt - d0); end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_good_block();
    test_bad_crc();
    test_token_error();
    test_timeout();
    test_abort();
    test_rst_midblock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
